// File: rtl/reset_sequencer_pkg.sv
// Shared types, widths and FSM state codes for the staged reset sequencer.
// Also provides the lowest-set-bit helper used for loss-of-lock re-sequencing.
package reset_sequencer_pkg;

  localparam int TMR_W   = 16;
  localparam int STAGE_W = 3;

  typedef logic [TMR_W-1:0]   tmr_t;
  typedef logic [STAGE_W-1:0] stage_t;
  typedef logic [2:0]         state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HOLD = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_NEXT = 3'd3;
  localparam state_t ST_RUN  = 3'd4;
  localparam state_t ST_FAIL = 3'd5;

  // Scans from the top so the final assignment is the lowest set bit.
  function automatic stage_t lowest_set(input logic [7:0] v);
    stage_t idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = stage_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the logic it releases.
// The sequencer drives through master; the stage owners (or a bench) use slave.
interface reset_sequencer_if #(
  parameter int NSTG = 4
);
  logic             soft_rst;
  logic [NSTG-1:0]  done;
  logic [NSTG-1:0]  stg_rst;
  logic             sys_rst;
  logic             ready;
  logic [NSTG-1:0]  err;
  logic [2:0]       stage;
  logic [2:0]       state;
  logic [1:0]       retries;

  modport master (
    input  soft_rst, done,
    output stg_rst, sys_rst, ready, err, stage, state, retries
  );

  modport slave (
    output soft_rst, done,
    input  stg_rst, sys_rst, ready, err, stage, state, retries
  );
endinterface

// File: rtl/rst_seq_tick.sv
// Free-running prescaler: counts 0..PRE_DIV-1 and emits a registered
// one-cycle tick on every wrap.
module rst_seq_tick #(
  parameter int PRE_DIV = 400
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(PRE_DIV - 1));

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    tick_d = wrap;
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/reset_sequencer.sv
// N-stage reset sequencer: releases stage resets in order, waits for each
// stage's done/lock, retries on timeout and re-sequences on loss of lock.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int                      NSTG         = 4,
  parameter int                      PRE_DIV      = 400,
  parameter tmr_t                    HOLD_TK      = 16'd10,
  parameter logic [NSTG*TMR_W-1:0]   TMO_TK       = {NSTG{16'd1000}},
  parameter int                      MAX_RETRY    = 3,
  parameter bit                      STALL_ON_ERR = 1'b1,
  parameter logic [NSTG-1:0]         MON_MASK     = {NSTG{1'b1}}
) (
  input  logic               clk_i,
  input  logic               rst_i,
  reset_sequencer_if.master  bus
);

  if (NSTG < 1 || NSTG > 8) begin : g_bad_nstg
    $error("reset_sequencer: NSTG must be in 1..8");
  end
  if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_retry
    $error("reset_sequencer: MAX_RETRY must fit the 2-bit retry counter");
  end

  logic            tick;
  state_t          state_q, state_d;
  stage_t          stage_q, stage_d;
  logic [1:0]      retries_q, retries_d;
  logic [NSTG-1:0] stg_rst_q, stg_rst_d;
  logic [NSTG-1:0] err_q, err_d;
  logic            sys_rst_q, sys_rst_d;
  logic            ready_q, ready_d;
  tmr_t            tmr_q, tmr_d;
  logic [NSTG-1:0] sync1_q, done_s_q, done_prev_q;

  logic [NSTG-1:0] stage_oh, hi_mask, fell;
  logic [7:0]      fell8;
  stage_t          lo_idx;
  tmr_t            tmo_cur;
  logic            cur_done, last_stage, restart;

  rst_seq_tick #(.PRE_DIV(PRE_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Only monitored stages that were locked and have just dropped count as loss of lock.
  assign fell       = done_prev_q & ~done_s_q & MON_MASK;
  assign lo_idx     = lowest_set(fell8);
  assign last_stage = (stage_q == stage_t'(NSTG - 1));
  assign cur_done   = |(done_s_q & stage_oh);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    fell8           = '0;
    fell8[NSTG-1:0] = fell;
    stage_oh        = '0;
    hi_mask         = '0;
    tmo_cur         = '0;
    for (int k = 0; k < NSTG; k++) begin
      stage_oh[k] = (stage_q == stage_t'(k));
      hi_mask[k]  = (stage_t'(k) >= lo_idx);
      if (stage_q == stage_t'(k)) tmo_cur = TMO_TK[k*TMR_W +: TMR_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    retries_d = retries_q;
    stg_rst_d = stg_rst_q;
    err_d     = err_q;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    if (bus.soft_rst) begin
      state_d   = ST_HOLD;
      stage_d   = '0;
      retries_d = '0;
      stg_rst_d = '1;
      err_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HOLD;
          stage_d = '0;
        end
        ST_HOLD: begin
          if (tmr_q == HOLD_TK) begin
            stg_rst_d = stg_rst_q & ~stage_oh;
            state_d   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done seen in the same cycle as the timeout takes precedence.
          if (cur_done) begin
            state_d = ST_NEXT;
          end else if (tmo_cur != '0 && tmr_q == tmo_cur) begin
            if (int'(retries_q) < MAX_RETRY) begin
              retries_d = retries_q + 2'd1;
              stg_rst_d = stg_rst_q | stage_oh;
              state_d   = ST_HOLD;
            end else begin
              err_d = err_q | stage_oh;
              if (STALL_ON_ERR) begin
                stg_rst_d = stg_rst_q | stage_oh;
                state_d   = ST_FAIL;
              end else begin
                state_d = ST_NEXT;
              end
            end
          end
        end
        ST_NEXT: begin
          if (last_stage) begin
            state_d = ST_RUN;
          end else begin
            stage_d   = stage_q + 3'd1;
            retries_d = '0;
            state_d   = ST_HOLD;
          end
        end
        ST_RUN: begin
          if (|fell) begin
            stage_d   = lo_idx;
            stg_rst_d = stg_rst_q | hi_mask;
            retries_d = '0;
            state_d   = ST_HOLD;
          end else begin
            sys_rst_d = 1'b0;
            ready_d   = 1'b1;
          end
        end
        ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Timer restarts on every state entry and for as long as a soft reset is held.
  assign restart = bus.soft_rst || (state_d != state_q);

  always_comb begin
    tmr_d = tmr_q;
    if (restart)                    tmr_d = '0;
    else if (tick && tmr_q != '1)   tmr_d = tmr_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      retries_q   <= '0;
      stg_rst_q   <= '1;
      err_q       <= '0;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      tmr_q       <= '0;
      sync1_q     <= '0;
      done_s_q    <= '0;
      done_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      retries_q   <= retries_d;
      stg_rst_q   <= stg_rst_d;
      err_q       <= err_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      tmr_q       <= tmr_d;
      sync1_q     <= bus.done;
      done_s_q    <= sync1_q;
      done_prev_q <= done_s_q;
    end
  end

  assign bus.stg_rst = stg_rst_q;
  assign bus.sys_rst = sys_rst_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign bus.stage   = stage_q;
  assign bus.state   = state_q;
  assign bus.retries = retries_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a cycle-exact release table plus
// hand-written retry, fail, loss-of-lock, soft-reset and no-timeout sequences.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reset_sequencer_if #(.NSTG(4)) bus_a ();
  reset_sequencer_if #(.NSTG(4)) bus_b ();

  reset_sequencer #(
    .NSTG(4), .PRE_DIV(4), .HOLD_TK(16'd2),
    .TMO_TK({16'd5, 16'd5, 16'd5, 16'd0}),
    .MAX_RETRY(3), .STALL_ON_ERR(1'b1), .MON_MASK(4'hF)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a)
  );

  reset_sequencer #(
    .NSTG(4), .PRE_DIV(4), .HOLD_TK(16'd2),
    .TMO_TK({16'd5, 16'd5, 16'd5, 16'd5}),
    .MAX_RETRY(3), .STALL_ON_ERR(1'b0), .MON_MASK(4'hF)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [3:0] done;
    logic [3:0] stg;
    logic [2:0] st;
    logic [2:0] stage;
    logic       rdy;
    logic       srst;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input logic [3:0] done_a);
    rst            = 1'b1;
    bus_a.soft_rst = 1'b0;
    bus_a.done     = done_a;
    step(2);
    check("rst stg_rst", bus_a.stg_rst, 4'hF);
    check("rst state",   bus_a.state,   ST_IDLE);
    check("rst ready",   bus_a.ready,   1'b0);
    check("rst sys_rst", bus_a.sys_rst, 1'b1);
    check("rst err",     bus_a.err,     4'h0);
    check("rst retries", bus_a.retries, 2'd0);
    rst = 1'b0;
  endtask

  task automatic wait_a(input logic [2:0] st, input logic [2:0] stg_idx, input int budget,
                        input string name);
    int n = 0;
    while (!(bus_a.state == st && bus_a.stage == stg_idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {bus_a.stage, bus_a.state}, {stg_idx, st});
  endtask

  initial begin
    int cur;
    int n;
    int reasserts;
    logic prev1;

    tbl[0]  = '{0,  4'hF, 4'hF, ST_IDLE, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1,  4'hF, 4'hF, ST_HOLD, 3'd0, 1'b0, 1'b1};
    tbl[2]  = '{9,  4'hF, 4'hF, ST_HOLD, 3'd0, 1'b0, 1'b1};
    tbl[3]  = '{10, 4'hF, 4'hE, ST_WAIT, 3'd0, 1'b0, 1'b1};
    tbl[4]  = '{11, 4'hF, 4'hE, ST_NEXT, 3'd0, 1'b0, 1'b1};
    tbl[5]  = '{12, 4'hF, 4'hE, ST_HOLD, 3'd1, 1'b0, 1'b1};
    tbl[6]  = '{17, 4'hF, 4'hE, ST_HOLD, 3'd1, 1'b0, 1'b1};
    tbl[7]  = '{18, 4'hF, 4'hC, ST_WAIT, 3'd1, 1'b0, 1'b1};
    tbl[8]  = '{26, 4'hF, 4'h8, ST_WAIT, 3'd2, 1'b0, 1'b1};
    tbl[9]  = '{34, 4'hF, 4'h0, ST_WAIT, 3'd3, 1'b0, 1'b1};
    tbl[10] = '{35, 4'hF, 4'h0, ST_NEXT, 3'd3, 1'b0, 1'b1};
    tbl[11] = '{36, 4'hF, 4'h0, ST_RUN,  3'd3, 1'b0, 1'b1};
    tbl[12] = '{37, 4'hF, 4'h0, ST_RUN,  3'd3, 1'b1, 1'b0};

    bus_b.soft_rst = 1'b0;
    bus_b.done     = 4'b1101;

    // Full release with every stage locked: cycle-exact against the table.
    apply_reset(4'hF);
    cur = 0;
    for (int i = 0; i < 13; i++) begin
      bus_a.done = tbl[i].done;
      if (tbl[i].cyc > cur) step(tbl[i].cyc - cur);
      cur = tbl[i].cyc;
      check($sformatf("seq@%0d stg_rst", cur), bus_a.stg_rst, tbl[i].stg);
      check($sformatf("seq@%0d state", cur),   bus_a.state,   tbl[i].st);
      check($sformatf("seq@%0d stage", cur),   bus_a.stage,   tbl[i].stage);
      check($sformatf("seq@%0d ready", cur),   bus_a.ready,   tbl[i].rdy);
      check($sformatf("seq@%0d sys_rst", cur), bus_a.sys_rst, tbl[i].srst);
    end

    // Loss of lock on stage 2 while running.
    bus_a.done = 4'b1011;
    step(2);
    check("lol still ready", bus_a.ready, 1'b1);
    step(1);
    check("lol stg_rst", bus_a.stg_rst, 4'hC);
    check("lol ready",   bus_a.ready,   1'b0);
    check("lol sys_rst", bus_a.sys_rst, 1'b1);
    check("lol state",   bus_a.state,   ST_HOLD);
    check("lol stage",   bus_a.stage,   3'd2);
    step(7);
    bus_a.done = 4'hF;
    wait_a(ST_RUN, 3'd3, 200, "lol back to run");
    step(1);
    check("lol rerun ready", bus_a.ready,   1'b1);
    check("lol rerun stg",   bus_a.stg_rst, 4'h0);

    // Soft reset in WAIT of stage 2 coinciding with its done.
    apply_reset(4'b1011);
    wait_a(ST_WAIT, 3'd2, 200, "sr reach wait2");
    bus_a.done = 4'hF;
    step(2);
    bus_a.soft_rst = 1'b1;
    step(1);
    check("sr state",   bus_a.state,   ST_HOLD);
    check("sr stage",   bus_a.stage,   3'd0);
    check("sr stg_rst", bus_a.stg_rst, 4'hF);
    check("sr err",     bus_a.err,     4'h0);
    step(20);
    check("sr held stg_rst", bus_a.stg_rst, 4'hF);
    check("sr held state",   bus_a.state,   ST_HOLD);
    bus_a.soft_rst = 1'b0;
    wait_a(ST_WAIT, 3'd0, 20, "sr release wait0");
    wait_a(ST_WAIT, 3'd1, 40, "sr reach wait1");
    #2 rst = 1'b1;
    #1;
    check("async stg_rst", bus_a.stg_rst, 4'hF);
    check("async state",   bus_a.state,   ST_IDLE);
    check("async stage",   bus_a.stage,   3'd0);

    // Stage 1 never locks: dut_a stalls in FAIL, dut_b flags and carries on.
    apply_reset(4'b1101);
    reasserts = 0;
    prev1     = bus_a.stg_rst[1];
    n         = 0;
    while (!(bus_a.state == ST_FAIL && bus_b.ready == 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
      if (!prev1 && bus_a.stg_rst[1] && bus_a.state == ST_HOLD) reasserts++;
      prev1 = bus_a.stg_rst[1];
    end
    check("fail reasserts", reasserts,     3);
    check("fail state",     bus_a.state,   ST_FAIL);
    check("fail err",       bus_a.err,     4'b0010);
    check("fail stg_rst",   bus_a.stg_rst, 4'b1110);
    check("fail stage",     bus_a.stage,   3'd1);
    check("fail retries",   bus_a.retries, 2'd3);
    check("fail ready",     bus_a.ready,   1'b0);
    check("nostall state",  bus_b.state,   ST_RUN);
    check("nostall ready",  bus_b.ready,   1'b1);
    check("nostall err",    bus_b.err,     4'b0010);
    check("nostall hi stg", bus_b.stg_rst[3:2], 2'b00);
    step(50);
    check("fail hold state", bus_a.state,   ST_FAIL);
    check("fail hold stg",   bus_a.stg_rst, 4'b1110);
    bus_a.soft_rst = 1'b1;
    step(1);
    bus_a.soft_rst = 1'b0;
    check("fail exit err",   bus_a.err,     4'h0);
    check("fail exit stg",   bus_a.stg_rst, 4'hF);
    check("fail exit state", bus_a.state,   ST_HOLD);
    check("fail exit stage", bus_a.stage,   3'd0);

    // Stage 0 has no timeout: waits indefinitely without retry or error.
    apply_reset(4'b1110);
    step(20000);
    check("notmo state",   bus_a.state,   ST_WAIT);
    check("notmo stage",   bus_a.stage,   3'd0);
    check("notmo retries", bus_a.retries, 2'd0);
    check("notmo err",     bus_a.err,     4'h0);
    check("notmo stg_rst", bus_a.stg_rst, 4'hE);
    bus_a.done = 4'hF;
    wait_a(ST_RUN, 3'd3, 200, "notmo reach run");
    step(1);
    check("notmo ready", bus_a.ready, 1'b1);
    check("notmo err end", bus_a.err, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
